// File: rtl/disp_scan_s_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: blanking values and
// the active-low hex glyph table.
package disp_scan_s_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Segment vectors are {g,f,e,d,c,b,a}: bit 0 drives segment a, bit 6 segment g; 0 = lit.
    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/disp_scan_s_hex7seg.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex7seg_s
    import disp_scan_s_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan_s.sv
// Time-multiplexed 4-digit common-anode display driver; lanes and blank mask are
// snapshotted once per scan frame so a frame never mixes old and new values.
module disp_scan_s
    import disp_scan_s_pkg::*;
#(
    parameter  int REFRESH_DIV = 50000,
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d_disp0,
    input  logic [3:0] d_disp1,
    input  logic [3:0] d_disp2,
    input  logic [3:0] d_disp3,
    input  logic [3:0] blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       snap_q [4];
    logic [3:0]       snap_d [4];
    logic [3:0]       snap_blank_q, snap_blank_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             frame_tick_q, frame_tick_d;

    logic             tick;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg;

    assign tick = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        div_cnt_d    = div_cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        snap_d       = snap_q;
        snap_blank_d = snap_blank_q;
        frame_tick_d = 1'b0;
        if (tick) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
            // Frame boundary: the last digit slot is ending, so latch a fresh frame.
            if (idx_q == 2'd3) begin
                snap_d[0]    = d_disp0;
                snap_d[1]    = d_disp1;
                snap_d[2]    = d_disp2;
                snap_d[3]    = d_disp3;
                snap_blank_d = blank;
                frame_tick_d = 1'b1;
            end
        end
    end

    assign cur_nibble = snap_q[idx_q];

    hex7seg_s u_hex7seg (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (!snap_blank_q[idx_q]) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = cur_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= 2'd0;
            snap_q[0]    <= 4'h0;
            snap_q[1]    <= 4'h0;
            snap_q[2]    <= 4'h0;
            snap_q[3]    <= 4'h0;
            snap_blank_q <= 4'hF;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            snap_blank_q <= snap_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_s.sv
// Self-checking bench for disp_scan_s: directed vector table, hand-written corner
// sequences, and a cycle-by-cycle reference model under random lane traffic.
module tb_disp_scan_s;

    localparam int RD    = 4;
    localparam int FRAME = 4 * RD;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d_disp0, d_disp1, d_disp2, d_disp3;
    logic [3:0] blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_tick;

    int checks_total  = 0;
    int checks_passed = 0;

    disp_scan_s #(.REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_disp0    (d_disp0),
        .d_disp1    (d_disp1),
        .d_disp2    (d_disp2),
        .d_disp3    (d_disp3),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Glyph table written straight from the display datasheet ({g..a}, active-low).
    logic [6:0] ref_hex [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: edges since reset decide which digit slot is showing and
    // when a frame boundary happens; the shown frame is whatever was captured last.
    int         t = 0;
    int         slot;
    logic [3:0] m_snap [4];
    logic [3:0] m_blank;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_ft;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t       = 0;
            m_snap  = '{4'h0, 4'h0, 4'h0, 4'h0};
            m_blank = 4'hF;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_ft  = 1'b0;
            chk_en  = 1'b1;
        end else if (chk_en) begin
            slot = (t / RD) % 4;
            if (m_blank[slot]) begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end else begin
                exp_an       = 4'hF;
                exp_an[slot] = 1'b0;
                exp_seg      = ref_hex[m_snap[slot]];
            end
            t      = t + 1;
            exp_ft = ((t % FRAME) == 0);
            if (exp_ft) begin
                m_snap  = '{d_disp0, d_disp1, d_disp2, d_disp3};
                m_blank = blank;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] ea,
                               input logic [6:0] es, input logic ef);
        checks_total = checks_total + 1;
        if (an === ea && seg === es && frame_tick === ef) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("[TB] FAIL %s @%0t: got an=%b seg=%b ft=%b, want an=%b seg=%b ft=%b",
                     name, $time, an, seg, frame_tick, ea, es, ef);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        checks_total = checks_total + 1;
        if (got == want) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            checkOutput("model", exp_an, exp_seg, exp_ft);
            checkInt("one_digit_max", $countones(~an), ($countones(~an) <= 1) ? $countones(~an) : 1);
        end
    end

    task automatic tickCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitFrameTick(input string name);
        int n;
        n = 0;
        do begin
            tickCycle();
            n = n + 1;
        end while (frame_tick !== 1'b1 && n < 3 * FRAME);
        if (frame_tick !== 1'b1) checkInt({name, "_frame_tick_timeout"}, n, -1);
    endtask

    task automatic setLanes(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d, input logic [3:0] bl);
        d_disp0 = a;
        d_disp1 = b;
        d_disp2 = c;
        d_disp3 = d;
        blank   = bl;
    endtask

    typedef struct {
        string      name;
        logic [3:0] d0, d1, d2, d3;
        logic [3:0] bl;
        int         slot;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
    } vec_t;

    vec_t vecs [8];

    // Drive a record's lanes, let the next snapshot take them, then look at its slot.
    task automatic applyStimulus(input vec_t v);
        setLanes(v.d0, v.d1, v.d2, v.d3, v.bl);
        waitFrameTick(v.name);
        repeat (1 + RD * v.slot) tickCycle();
        checkOutput(v.name, v.exp_an, v.exp_seg, 1'b0);
    endtask

    initial begin
        int n;

        vecs[0] = '{"scan_d0", 4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 0, 4'b1110, 7'b1111001};
        vecs[1] = '{"scan_d1", 4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 1, 4'b1101, 7'b0100100};
        vecs[2] = '{"scan_d2", 4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 2, 4'b1011, 7'b0110000};
        vecs[3] = '{"scan_d3", 4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 3, 4'b0111, 7'b0011001};
        vecs[4] = '{"blank_d0", 4'h8, 4'h8, 4'h8, 4'h8, 4'b0101, 0, 4'b1111, 7'b1111111};
        vecs[5] = '{"blank_d1", 4'h8, 4'h8, 4'h8, 4'h8, 4'b0101, 1, 4'b1101, 7'b0000000};
        vecs[6] = '{"blank_d2", 4'h8, 4'h8, 4'h8, 4'h8, 4'b0101, 2, 4'b1111, 7'b1111111};
        vecs[7] = '{"blank_d3", 4'h8, 4'h8, 4'h8, 4'h8, 4'b0101, 3, 4'b0111, 7'b0000000};

        rst = 1'b1;
        setLanes(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (3) begin
            tickCycle();
            checkOutput("reset_state", 4'hF, 7'h7F, 1'b0);
        end
        rst = 1'b0;
        setLanes(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);

        for (int i = 1; i < FRAME; i++) begin
            tickCycle();
            checkOutput("first_frame_blank", 4'hF, 7'h7F, 1'b0);
        end
        tickCycle();
        checkOutput("first_snapshot", 4'hF, 7'h7F, 1'b1);
        tickCycle();
        checkOutput("first_digit0", 4'b1110, 7'b1111001, 1'b0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("[TB] frame coherence");
        setLanes(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
        waitFrameTick("coh_a");
        repeat (2) tickCycle();
        d_disp2 = 4'hF;
        repeat (7) tickCycle();
        checkOutput("coherence_old", 4'b1011, 7'b0110000, 1'b0);
        waitFrameTick("coh_b");
        repeat (9) tickCycle();
        checkOutput("coherence_new", 4'b1011, 7'b0001110, 1'b0);

        $display("[TB] decode sweep");
        for (int v = 0; v < 16; v++) begin
            setLanes(4'(v), 4'h0, 4'h0, 4'h0, 4'b0000);
            waitFrameTick("sweep");
            tickCycle();
            checkOutput("sweep_digit0", 4'b1110, ref_hex[v], 1'b0);
        end

        $display("[TB] reset mid-scan");
        setLanes(4'h5, 4'h6, 4'h7, 4'h9, 4'b0000);
        waitFrameTick("midscan");
        repeat (9) tickCycle();
        rst = 1'b1;
        tickCycle();
        checkOutput("midscan_reset", 4'hF, 7'h7F, 1'b0);
        rst = 1'b0;
        n = 0;
        do begin
            tickCycle();
            n = n + 1;
        end while (frame_tick !== 1'b1 && n < 3 * FRAME);
        checkInt("midscan_next_boundary", n, FRAME);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            setLanes(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                     4'($urandom));
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            tickCycle();
            rst = 1'b0;
        end
        rst = 1'b0;
        tickCycle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
